// File: rtl/hci_streamer_sequencer_pkg.sv
// Streamer-side types (hwpe_stream_package) and sequencer-facing types plus
// the sequencer state enum (hci_package).
package hwpe_stream_package;

    typedef struct packed {
        logic [15:0] base_addr;
        logic [15:0] tot_len;
        logic [15:0] d0_stride;
        logic [1:0]  dim_enable_1h;
    } ctrl_addressgen_v3_t;

    typedef struct packed {
        logic done;
    } flags_addressgen_v3_t;

endpackage

package hci_package;

    import hwpe_stream_package::*;

    typedef struct packed {
        logic                req_start;
        ctrl_addressgen_v3_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    typedef struct packed {
        logic                 ready_start;
        logic                 done;
        flags_addressgen_v3_t addressgen_flags;
    } hci_streamer_flags_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_RESP  = 2'd3
    } hci_streamer_seq_state_t;

endpackage

// File: rtl/hci_streamer_sequencer_watchdog.sv
// WAIT-phase watchdog for the streamer sequencer; built only when
// HCI_STREAMER_SEQ_WATCHDOG_EN is defined.
module hci_streamer_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // Counter is held at zero outside WAIT, so every entry into WAIT starts from 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i || !enable_i) begin
            cnt_q <= '0;
        end else if (!expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Fires in the WAIT cycle whose increment brings the count to the limit.
    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hci_streamer_sequencer.sv
// Single-job sequencer in front of an HCI streamer: issue, wait for done, report.
// Optional WAIT watchdog enabled by defining HCI_STREAMER_SEQ_WATCHDOG_EN.
//
// state     | meaning
// SEQ_IDLE  | ready for a job, last config kept on ctrl_o
// SEQ_ISSUE | req_start high until the streamer takes it
// SEQ_WAIT  | streamer running, waiting for done (or timeout)
// SEQ_RESP  | completion report held until consumed
module hci_streamer_sequencer
    import hwpe_stream_package::*;
    import hci_package::*;
#(
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  ctrl_addressgen_v3_t   job_ctrl_i,
    input  logic [ID_WIDTH-1:0]   job_id_i,
    output hci_streamer_ctrl_t    ctrl_o,
    input  hci_streamer_flags_t   flags_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [ID_WIDTH-1:0]   resp_id_o,
    output logic                  resp_err_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  done_cnt_o
);

    hci_streamer_seq_state_t state_q, state_d;
    ctrl_addressgen_v3_t     cfg_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    timeout;
    logic                    unused_flags;

    assign unused_flags = ^flags_i.addressgen_flags;

`ifdef HCI_STREAMER_SEQ_WATCHDOG_EN
    logic err_q;

    hci_streamer_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable_i  (state_q == SEQ_WAIT),
        .clear_i   (clear_i),
        .expired_o (timeout)
    );

    // Done wins a tie with the timeout; the flag is frozen once RESP is entered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (state_q == SEQ_WAIT && !clear_i) begin
            err_q <= timeout && !flags_i.done;
        end
    end

    assign resp_err_o = err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

    assign timeout    = 1'b0;
    assign resp_err_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:  if (job_valid_i)                 state_d = SEQ_ISSUE;
            SEQ_ISSUE: if (flags_i.ready_start)         state_d = SEQ_WAIT;
            SEQ_WAIT:  if (flags_i.done || timeout)     state_d = SEQ_RESP;
            SEQ_RESP:  if (resp_ready_i)                state_d = SEQ_IDLE;
            default:                                    state_d = SEQ_IDLE;
        endcase
        if (clear_i) begin
            state_d = SEQ_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SEQ_IDLE;
            cfg_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SEQ_IDLE && job_valid_i && !clear_i) begin
                cfg_q <= job_ctrl_i;
                id_q  <= job_id_i;
            end
            if (clear_i) begin
                cnt_q <= '0;
            end else if (state_q == SEQ_RESP && resp_ready_i) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign job_ready_o            = (state_q == SEQ_IDLE);
    assign ctrl_o.req_start       = (state_q == SEQ_ISSUE);
    assign ctrl_o.addressgen_ctrl = cfg_q;
    assign resp_valid_o           = (state_q == SEQ_RESP);
    assign resp_id_o              = id_q;
    assign busy_o                 = (state_q != SEQ_IDLE);
    assign done_cnt_o             = cnt_q;

endmodule

// File: doc/hci_streamer_sequencer.md
HCI_STREAMER_SEQUENCER -- requirements
Module: hci_streamer_sequencer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, width of the job tag.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the completed-job counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit in cycles (used only with the macro).
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 clear_i  input  1  synchronous soft clear, active-high.
REQ-007 job_valid_i  input  1  job offer valid.
REQ-008 job_ready_o  output  1  job accepted when valid and ready are both high.
REQ-009 job_ctrl_i  input  $bits(ctrl_addressgen_v3_t)  address-generator config for the job.
REQ-010 job_id_i  input  ID_WIDTH  job tag.
REQ-011 ctrl_o  output  hci_streamer_ctrl_t  req_start plus addressgen_ctrl to the streamer.
REQ-012 flags_i  input  hci_streamer_flags_t  ready_start and done from the streamer; addressgen_flags ignored.
REQ-013 resp_valid_o  output  1  completion report valid.
REQ-014 resp_ready_i  input  1  completion report consumed.
REQ-015 resp_id_o  output  ID_WIDTH  tag of the completed job.
REQ-016 resp_err_o  output  1  job ended by watchdog timeout.
REQ-017 busy_o  output  1  high in every state except IDLE.
REQ-018 done_cnt_o  output  CNT_WIDTH  number of completion handshakes since reset or clear.

Function
REQ-019 SHALL implement an FSM with states IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE: job_ready_o=1; on job handshake, SHALL latch job_ctrl_i and job_id_i and go to ISSUE next cycle.
REQ-021 job_ready_o SHALL be 0 in every state other than IDLE; there is no job queueing.
REQ-022 ISSUE: ctrl_o.req_start=1, held until flags_i.ready_start=1 in the same cycle; then go to WAIT.
REQ-023 ctrl_o.req_start SHALL be 0 in all states other than ISSUE.
REQ-024 ctrl_o.addressgen_ctrl SHALL present the latched job config, stable from ISSUE through RESP; it keeps the last value in IDLE.
REQ-025 flags_i.done SHALL be sampled only in WAIT; done in ISSUE (including the start-handshake cycle) SHALL be ignored.
REQ-026 WAIT: on flags_i.done=1, go to RESP with resp_err_o=0.
REQ-027 RESP: resp_valid_o=1 with resp_id_o equal to the latched tag; resp_id_o and resp_err_o held stable until resp_ready_i=1, then go to IDLE.
REQ-028 The earliest job_ready_o after a completion handshake SHALL be the following cycle; the minimum job period is 4 cycles.
REQ-029 done_cnt_o SHALL increment by 1 on each completion handshake, wrap from 2^CNT_WIDTH-1 to 0, and count error completions too.
REQ-030 clear_i=1 SHALL force IDLE next cycle from any state, drop any pending response, zero done_cnt_o, and take priority over every handshake in the same cycle.

Reset
REQ-031 On rst_ni=0 at a clock edge, the block SHALL reset to: state IDLE, ctrl_o all zeros, resp_valid_o=0, resp_id_o=0, resp_err_o=0, busy_o=0, done_cnt_o=0, latched config and tag zero, watchdog counter zero.
REQ-032 Reset during ISSUE or WAIT SHALL abandon the job with no response and no req_start in the next cycle.

Configuration
REQ-033 With macro HCI_STREAMER_SEQ_WATCHDOG_EN defined: a counter cleared on entry to WAIT increments each WAIT cycle; on reaching TIMEOUT_CYCLES without done, the FSM SHALL go to RESP with resp_err_o=1.
REQ-034 On a timeout tie (done and counter at limit in the same cycle), done SHALL win and resp_err_o SHALL be 0.
REQ-035 Without HCI_STREAMER_SEQ_WATCHDOG_EN: no counter is built, resp_err_o SHALL be tied 0, and WAIT lasts until done.

Structure
REQ-036 The state enum hci_streamer_seq_state_t SHALL be added to hci_package; the streamer types are reused from hci_package and hwpe_stream_package.
REQ-037 The watchdog SHALL be a sub-module hci_streamer_seq_watchdog (enable, clear, expired), instantiated only under the macro.

Verification
REQ-038 Job id=3, ready_start high -> req_start for 1 cycle, done after 10 cycles -> resp_id_o=3, resp_err_o=0, done_cnt_o=1.
REQ-039 ready_start held low 5 cycles -> req_start stays high for 6 cycles and the config stays stable; done pulsed during ISSUE is ignored.
REQ-040 resp_ready_i held low 4 cycles in RESP -> resp_valid_o, resp_id_o stable; job_valid_i held high during this time is not accepted.
REQ-041 clear_i asserted in WAIT together with done -> IDLE next cycle, no response, done_cnt_o=0.
REQ-042 Macro defined with TIMEOUT_CYCLES=8 and no done -> resp_err_o=1 after 8 WAIT cycles; repeat with done on cycle 8 -> resp_err_o=0.
REQ-043 CNT_WIDTH=2, 5 jobs completed -> done_cnt_o sequence 1,2,3,0,1.
